// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control path
package ctrl_pkg;

  // Major opcodes the datapath executes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Branch funct3 values handled in BRANCH
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Controller states
  typedef logic [3:0] state_t;
  localparam state_t S_RST_WAIT = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEMADR   = 4'd3;
  localparam state_t S_MEMRD    = 4'd4;
  localparam state_t S_MEMWB    = 4'd5;
  localparam state_t S_MEMWR    = 4'd6;
  localparam state_t S_EXEC_R   = 4'd7;
  localparam state_t S_EXEC_I   = 4'd8;
  localparam state_t S_ALUWB    = 4'd9;
  localparam state_t S_BRANCH   = 4'd10;
  localparam state_t S_TRAP     = 4'd11;

  // Immediate generator format select
  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_sel_e;

  // ALU operand B source
  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } srcb_e;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  // States that hold mem_req and therefore run the wait timer
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory wait-cycle counter with expiry flag
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Count value during the MEM_TIMEOUT-th waiting cycle
  localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // A timeout of 0 never expires; the counter then simply free-runs
  assign expired = (MEM_TIMEOUT != 0) && (cnt == LAST);

  // Count waiting cycles; clear wins, and the count parks once expired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the RV32I subset datapath
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] imm_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       retire,
  output logic       illegal
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hold_cnt;
  logic        hold_done;
  logic        in_mem;
  logic        timer_clr;
  logic        expired;

  // RST_WAIT always lasts at least one cycle, even with a hold of 0
  assign hold_done = (hold_cnt + 32'd1) >= RESET_PC_HOLD;

  // Restart the wait count on every entry to a memory state, including
  // MEMWR -> FETCH where both sides hold mem_req
  assign in_mem    = is_mem_state(state);
  assign timer_clr = !in_mem || (state_nxt != state);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (timer_clr),
    .en     (in_mem),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Cycles spent in RST_WAIT before the first fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state == S_RST_WAIT) begin
      hold_cnt <= hold_cnt + 32'd1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Next-state and control decode; mem_ready wins over an expiring timer
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    imm_sel   = IMM_NONE;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_RST_WAIT: begin
        if (hold_done) state_nxt = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (expired) begin
          state_nxt = S_TRAP;
        end
      end

      S_DECODE: begin
        // Branch target lands in the ALU-out register for BRANCH to use
        imm_sel   = IMM_B;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_OP:             state_nxt = S_EXEC_R;
          OP_OPIMM:          state_nxt = S_EXEC_I;
          OP_BRANCH:         state_nxt = S_BRANCH;
          default:           state_nxt = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          state_nxt = S_MEMWB;
        end else if (expired) begin
          state_nxt = S_TRAP;
        end
      end

      S_MEMWB: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (expired) begin
          state_nxt = S_TRAP;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_nxt = S_ALUWB;
      end

      S_EXEC_I: begin
        imm_sel   = IMM_I;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_nxt = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_BRANCH: begin
        // rs1 - rs2 drives zero; the PC takes the precomputed target
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        if (funct3 == F3_BEQ) begin
          pc_write  = zero;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (funct3 == F3_BNE) begin
          pc_write  = !zero;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_TRAP;
        end
      end

      S_TRAP: begin
        illegal = 1'b1;
      end

      default: begin
        state_nxt = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src;
  logic [1:0] imm_sel, alu_src_b, alu_op;
  logic alu_src_a, reg_write, wb_sel, retire, illegal;

  logic z_mem_req, z_mem_we, z_addr_sel, z_ir_write, z_pc_write, z_pc_src;
  logic [1:0] z_imm_sel, z_alu_src_b, z_alu_op;
  logic z_alu_src_a, z_reg_write, z_wb_sel, z_retire, z_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .RESET_PC_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .illegal(illegal)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(0), .RESET_PC_HOLD(1)) dut_notimeout (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(z_mem_req), .mem_we(z_mem_we), .addr_sel(z_addr_sel),
    .ir_write(z_ir_write), .pc_write(z_pc_write), .pc_src(z_pc_src), .imm_sel(z_imm_sel),
    .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .alu_op(z_alu_op),
    .reg_write(z_reg_write), .wb_sel(z_wb_sel), .retire(z_retire), .illegal(z_illegal)
  );

  // {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sel,
  //  alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, illegal}
  logic [16:0] obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, imm_sel,
                alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, retire, illegal};

  localparam logic [16:0] E_RST     = {6'b000000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] E_FETCH_W = {6'b100000, 2'b11, 1'b0, 2'b01, 2'b00, 4'b0000};
  localparam logic [16:0] E_FETCH_R = {6'b100110, 2'b11, 1'b0, 2'b01, 2'b00, 4'b0000};
  localparam logic [16:0] E_DECODE  = {6'b000000, 2'b10, 1'b0, 2'b10, 2'b00, 4'b0000};
  localparam logic [16:0] E_MA_LW   = {6'b000000, 2'b00, 1'b1, 2'b10, 2'b00, 4'b0000};
  localparam logic [16:0] E_MA_SW   = {6'b000000, 2'b01, 1'b1, 2'b10, 2'b00, 4'b0000};
  localparam logic [16:0] E_MEMRD   = {6'b101000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] E_MEMWB   = {6'b000000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b1110};
  localparam logic [16:0] E_MEMWR_W = {6'b111000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b0000};
  localparam logic [16:0] E_MEMWR_R = {6'b111000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [16:0] E_EXEC_R  = {6'b000000, 2'b11, 1'b1, 2'b00, 2'b10, 4'b0000};
  localparam logic [16:0] E_EXEC_I  = {6'b000000, 2'b00, 1'b1, 2'b10, 2'b10, 4'b0000};
  localparam logic [16:0] E_ALUWB   = {6'b000000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b1010};
  localparam logic [16:0] E_BR_T    = {6'b000011, 2'b11, 1'b1, 2'b00, 2'b01, 4'b0010};
  localparam logic [16:0] E_BR_N    = {6'b000001, 2'b11, 1'b1, 2'b00, 2'b01, 4'b0010};
  localparam logic [16:0] E_BR_X    = {6'b000001, 2'b11, 1'b1, 2'b00, 2'b01, 4'b0000};
  localparam logic [16:0] E_TRAP    = {6'b000000, 2'b11, 1'b0, 2'b00, 2'b00, 4'b0001};

  // Hold reset across an edge, release 1 ns after it: first RST_WAIT cycle follows
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [17:0] seq [$];
    opcode = 7'b0110011;
    funct3 = 3'b000;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL reset_asserted: got %b expected %b", obs, E_RST);
    end
    do_reset();
    seq = '{{1'b0, E_RST}, {1'b0, E_FETCH_W}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    logic [17:0] seq [$];
    opcode = 7'b0100011;
    funct3 = 3'b010;
    do_reset();
    seq = '{{1'b0, E_RST}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b0, E_MA_SW},
            {1'b0, E_MEMWR_W}};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL memwr_pre_reset cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || obs !== E_RST) begin
      errors++;
      $display("FAIL async_reset_drop: got %b expected %b", obs, E_RST);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== E_RST) begin
      errors++;
      $display("FAIL reset_hold_cycle: got %b expected %b", obs, E_RST);
    end
    @(posedge clk);
    #2;
    checks++;
    if (obs !== E_FETCH_R) begin
      errors++;
      $display("FAIL first_fetch_after_hold: got %b expected %b", obs, E_FETCH_R);
    end
  endtask

  task automatic test_lw_stall();
    logic [17:0] seq [$];
    int ret_at = -1;
    int wb_cycles = 0;
    opcode = 7'b0000011;
    funct3 = 3'b010;
    do_reset();
    seq = '{{1'b0, E_RST}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b0, E_MA_LW},
            {1'b0, E_MEMRD}, {1'b0, E_MEMRD}, {1'b1, E_MEMRD}, {1'b0, E_MEMWB},
            {1'b0, E_FETCH_W}};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL lw_stall cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
      if (retire === 1'b1 && ret_at < 0) ret_at = i;
      if (reg_write === 1'b1 && wb_sel === 1'b1) wb_cycles++;
    end
    checks++;
    if (ret_at - 1 + 1 !== 7) begin
      errors++;
      $display("FAIL lw_latency: got %0d expected 7", ret_at);
    end
    checks++;
    if (wb_cycles !== 1) begin
      errors++;
      $display("FAIL lw_wb_cycles: got %0d expected 1", wb_cycles);
    end
  endtask

  task automatic test_sw();
    logic [17:0] seq [$];
    int rw_cycles = 0;
    int we_cycles = 0;
    opcode = 7'b0100011;
    funct3 = 3'b010;
    do_reset();
    seq = '{{1'b0, E_RST}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b0, E_MA_SW},
            {1'b0, E_MEMWR_W}, {1'b1, E_MEMWR_R}, {1'b0, E_FETCH_W}};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL sw cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
      if (reg_write !== 1'b0) rw_cycles++;
      if (mem_we === 1'b1) we_cycles++;
    end
    checks++;
    if (rw_cycles !== 0 || we_cycles !== 2) begin
      errors++;
      $display("FAIL sw_strobes: reg_write cycles %0d mem_we cycles %0d expected 0 and 2",
               rw_cycles, we_cycles);
    end
  endtask

  task automatic test_branch();
    logic [17:0] seq [$];
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b100};
    logic [16:0] br_exp [3] = '{E_BR_T, E_BR_N, E_BR_X};
    logic [16:0] after [3] = '{E_FETCH_W, E_FETCH_W, E_TRAP};
    for (int k = 0; k < 3; k++) begin
      opcode = 7'b1100011;
      funct3 = f3s[k];
      zero   = 1'b1;
      do_reset();
      seq = '{{1'b0, E_RST}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b0, br_exp[k]},
              {1'b0, after[k]}};
      for (int i = 0; i < seq.size(); i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        mem_ready = seq[i][17];
        #1;
        checks++;
        if (obs !== seq[i][16:0]) begin
          errors++;
          $display("FAIL branch funct3=%b cycle %0d: got %b expected %b",
                   f3s[k], i, obs, seq[i][16:0]);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [17:0] seq [$];
    opcode = 7'b0110011;
    funct3 = 3'b000;
    do_reset();
    seq = '{{1'b0, E_RST}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b0, E_EXEC_R},
            {1'b0, E_ALUWB}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b0, E_EXEC_I},
            {1'b0, E_ALUWB}, {1'b0, E_FETCH_W}};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 5) opcode = 7'b0010011;
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
    end
  endtask

  task automatic test_illegal_opcode();
    logic [17:0] seq [$];
    opcode = 7'b1101111;
    funct3 = 3'b000;
    do_reset();
    seq = '{{1'b0, E_RST}, {1'b1, E_FETCH_R}, {1'b0, E_DECODE}, {1'b1, E_TRAP},
            {1'b1, E_TRAP}, {1'b1, E_TRAP}, {1'b0, E_TRAP}};
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL illegal_opcode cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [17:0] seq [$];
    opcode = 7'b0110011;
    funct3 = 3'b000;
    do_reset();
    seq.push_back({1'b0, E_RST});
    for (int n = 0; n < 16; n++) seq.push_back({1'b0, E_FETCH_W});
    seq.push_back({1'b0, E_TRAP});
    seq.push_back({1'b0, E_TRAP});
    for (int i = 0; i < seq.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ready = seq[i][17];
      #1;
      checks++;
      if (obs !== seq[i][16:0]) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %b expected %b", i, obs, seq[i][16:0]);
      end
      if (i > 0) begin
        checks++;
        if (z_mem_req !== 1'b1 || z_illegal !== 1'b0) begin
          errors++;
          $display("FAIL no_timeout_wait cycle %0d: mem_req %b illegal %b expected 1 and 0",
                   i, z_mem_req, z_illegal);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_memwr();
    test_lw_stall();
    test_sw();
    test_branch();
    test_back_to_back();
    test_illegal_opcode();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I subset the datapath executes: lw, sw, beq/bne (SB-type), addi/ori (I-type ALU) and R-type ALU.
- Sequences one instruction over 3–5+ cycles: fetch, decode, execute, memory, writeback.
- Drives the immediate-generator format select, ALU operand muxes, register-file and memory strobes, and PC updates.
- Handshakes with a shared instruction/data memory port that may stall.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- RESET_PC_HOLD, 1, cycles FETCH waits after reset release before the first mem_req.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- funct3  in  3  IR[14:12].
- zero  in  1  ALU zero flag from the current cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_we  out  1  write enable; valid with mem_req.
- addr_sel  out  1  0 = PC address, 1 = ALU-result address.
- ir_write  out  1  latch fetched instruction.
- pc_write  out  1  unconditional PC update.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- imm_sel  out  2  00 I, 01 S, 10 B, 11 none.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 rs2, 01 const 4, 10 immediate.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- reg_write  out  1  register-file write strobe.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky; set on unsupported opcode or timeout.

Behaviour:
- Reset: state = RST_WAIT; all outputs 0, except imm_sel = 11. Reset is asynchronous and may assert in any state, including with mem_req high; outputs drop immediately.
- RST_WAIT: hold RESET_PC_HOLD cycles, then go to FETCH.
- FETCH:
  - mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - imm_sel=10, alu_src_a=0, alu_src_b=10 precompute the branch target into the ALU-out register.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; anything else → TRAP.
- MEMADR: imm_sel = 00 (lw) or 01 (sw), alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, addr_sel=1, mem_we=0. On mem_ready go to MEMWB.
- MEMWB: reg_write=1, wb_sel=1, retire=1, then go to FETCH.
- MEMWR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready: retire=1, go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then go to ALUWB.
- EXEC_I: imm_sel=00, alu_src_a=1, alu_src_b=10, alu_op=10, then go to ALUWB.
- ALUWB: reg_write=1, wb_sel=0, retire=1, then go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Other funct3 values → TRAP with no PC write.
  - retire=1 when not trapping; next state FETCH.
- TRAP: illegal=1 (sticky); all strobes 0; remain in TRAP until rst_n.
- Timeout: a wait counter resets on entry to any mem_req state. If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT without mem_ready, go to TRAP and deassert mem_req the next cycle.
- Latency, zero-wait memory: beq/bne 3 cycles; R, I and sw 4; lw 5. Each wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.
- Outputs are combinational from state and inputs (Moore, except the BRANCH pc_write and the mem_ready-qualified strobes).

Decomposition:
- ctrl_pkg holds: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_OPIMM, OP_OP); state enum; imm_sel, alu_src_b and alu_op encodings. ImmGen and the ALU decoder share these.
- Sub-module mem_wait_timer: counter with clear/enable, parameterised by MEM_TIMEOUT, outputs expired.

Test Plan:
- Reset mid-MEMWR with mem_req=1, then release with zero-wait memory: mem_req drops asynchronously; after RESET_PC_HOLD=1 cycle, FETCH asserts mem_req with addr_sel=0.
- lw (opcode 0000011) with mem_ready delayed 2 cycles in MEMRD: imm_sel=00 in MEMADR; retire 7 cycles after fetch start; reg_write and wb_sel=1 in exactly one cycle.
- beq with zero=1 and bne with zero=1: beq gives pc_write=1, pc_src=1; bne gives pc_write=0. Both take 3 cycles and give retire=1.
- sw: imm_sel=01 in MEMADR, mem_we=1 in MEMWR only, reg_write never asserted.
- Opcode 1101111: TRAP after DECODE, illegal=1 sticky, no further mem_req until reset.
- mem_ready held low 16 cycles in FETCH: illegal=1 on cycle 17 and mem_req=0. With MEM_TIMEOUT=0 it waits indefinitely.
